// File: rtl/print_uart_tx_pkg.sv
// rtl/print_uart_tx_pkg.sv - shared types and constants for the print UART transmitter
// Purpose : FSM state enum, default timing/FIFO constants, drop counter width.
// Ports   : none (package).
package print_uart_pkg;

   localparam int DEF_CLK_DIV    = 868;   // 100 MHz / 115200 baud
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DROP_CNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/print_uart_tx_if.sv
// rtl/print_uart_tx_if.sv - print channel carrying one byte per strobe
// Purpose : groups the print strobe and byte from the data-memory print channel.
// Signals : print_valid - one-cycle strobe, print_value - byte sampled with the strobe.
// Modports: master drives the channel, slave (the transmitter) receives it.
interface print_uart_tx_if;

   logic       print_valid;
   logic [7:0] print_value;

   modport master (output print_valid, output print_value);
   modport slave  (input  print_valid, input  print_value);

endinterface

// File: rtl/print_fifo.sv
// rtl/print_fifo.sv - synchronous byte FIFO with wrapping pointers
// Purpose : buffers print bytes between the print channel and the serialiser.
// Ports   : clk, resetn (async, active-low); i_push/i_data write side;
//           i_pop/o_data read side (o_data is the head, valid when !o_empty);
//           o_full, o_empty status.
// The caller only pushes while full when a pop happens on the same edge; in that
// case the write lands in the slot being freed by the pop.
module print_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // index with differing wrap bit means full.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/print_uart_tx.sv
// rtl/print_uart_tx.sv - buffered 8N1 UART transmitter for the print channel
// Purpose : queues print bytes in a FIFO and serialises them as 8N1 frames.
// Ports   : clk, resetn (async, active-low); print_if (slave) print strobe/byte;
//           uart_tx serial line (idle high, registered); tx_busy frame or queue
//           pending; fifo_full; overflow sticky drop flag; drop_cnt saturating
//           count of dropped bytes.
module print_uart_tx
   import print_uart_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   print_uart_tx_if.slave        print_if,
   output logic                  uart_tx,
   output logic                  tx_busy,
   output logic                  fifo_full,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

   tx_state_e             r_state,   w_state_nxt;
   logic [15:0]           r_bit_cnt, w_bit_cnt_nxt;
   logic [2:0]            r_bit_idx, w_bit_idx_nxt;
   logic [7:0]            r_shift,   w_shift_nxt;
   logic                  r_tx,      w_line;
   logic                  r_overflow;
   logic [DROP_CNT_W-1:0] r_drop_cnt, w_drop_cnt_nxt;

   logic       w_pop;
   logic       w_accept;
   logic       w_drop;
   logic       w_bit_end;
   logic [7:0] w_fifo_data;
   logic       w_fifo_full;
   logic       w_fifo_empty;

   // A full FIFO still takes the byte when the serialiser pops on the same edge.
   assign w_accept = print_if.print_valid && (!w_fifo_full || w_pop);
   assign w_drop   = print_if.print_valid && w_fifo_full && !w_pop;

   print_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_accept),
      .i_data  (print_if.print_value),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign w_bit_end = (r_bit_cnt == 16'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_bit_cnt <= 16'd0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_line;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_pop         = 1'b0;
      w_line        = 1'b1;

      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop         = 1'b1;
               w_shift_nxt   = w_fifo_data;
               w_bit_cnt_nxt = DIV_M1;
               w_state_nxt   = START;
            end
         end
         START: begin
            w_line = 1'b0;
            if (w_bit_end) begin
               w_bit_cnt_nxt = DIV_M1;
               w_bit_idx_nxt = 3'd0;
               w_state_nxt   = DATA;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt - 16'd1;
            end
         end
         DATA: begin
            // The current data bit always sits in bit 0 of the shift register.
            w_line = r_shift[0];
            if (w_bit_end) begin
               w_bit_cnt_nxt = DIV_M1;
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_bit_cnt_nxt = r_bit_cnt - 16'd1;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               // Chain straight into the next frame so queued bytes leave no gap.
               if (!w_fifo_empty) begin
                  w_pop         = 1'b1;
                  w_shift_nxt   = w_fifo_data;
                  w_bit_cnt_nxt = DIV_M1;
                  w_state_nxt   = START;
               end else begin
                  w_state_nxt   = IDLE;
               end
            end else begin
               w_bit_cnt_nxt = r_bit_cnt - 16'd1;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = 16'd0;
         end
      endcase
   end

   always_comb begin
      w_drop_cnt_nxt = r_drop_cnt;
      if (w_drop && (r_drop_cnt != '1)) w_drop_cnt_nxt = r_drop_cnt + DROP_CNT_W'(1);
   end

   // The drop counter is rewritten every cycle so its value is always the
   // result of the previous one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_overflow <= r_overflow | w_drop;
         r_drop_cnt <= w_drop_cnt_nxt;
      end
   end

   assign uart_tx   = r_tx;
   assign tx_busy   = !((r_state == IDLE) && w_fifo_empty);
   assign fifo_full = w_fifo_full;
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_print_uart_tx.sv
// tb/tb_print_uart_tx.sv - scoreboard bench for print_uart_tx with CLK_DIV=4, FIFO_DEPTH=4
module tb_print_uart_tx;

   localparam int D     = 4;
   localparam int DEPTH = 4;

   typedef struct {
      int         start;
      logic [7:0] data;
   } frame_t;

   logic        clk;
   logic        resetn;
   logic        uart_tx;
   logic        tx_busy;
   logic        fifo_full;
   logic        overflow;
   logic [15:0] drop_cnt;

   print_uart_tx_if pif ();

   print_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .print_if  (pif),
      .uart_tx   (uart_tx),
      .tx_busy   (tx_busy),
      .fifo_full (fifo_full),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int          cyc = 0;
   int          m_free = 0;       // first edge at which the line may start a new pop
   logic [7:0]  m_fifo[$];
   frame_t      sb_q[$];
   logic [15:0] m_drop = 16'd0;
   logic        m_ovf = 1'b0;

   // Line monitor state
   logic mon_act = 1'b0;
   int   mon_s = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a frame occupies 10*D cycles from its pop edge; the next pop may
   // happen at the last of those edges. Bytes are accepted while fewer than
   // DEPTH are waiting, counting a pop on the same edge.
   always @(posedge clk) begin
      logic [7:0] b;
      frame_t     f;
      cyc++;
      if (!resetn) begin
         m_fifo.delete();
         sb_q.delete();
         m_free = 0;
         m_drop = 16'd0;
         m_ovf  = 1'b0;
      end else begin
         if (m_fifo.size() > 0 && cyc >= m_free) begin
            b       = m_fifo.pop_front();
            f.start = cyc + 1;
            f.data  = b;
            sb_q.push_back(f);
            m_free  = cyc + 10 * D;
         end
         if (pif.print_valid) begin
            if (m_fifo.size() < DEPTH) begin
               m_fifo.push_back(pif.print_value);
            end else begin
               m_ovf = 1'b1;
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
         end
      end
   end

   // Monitor: status outputs every cycle, line level against the expected frame.
   always @(negedge clk) begin
      int   bi;
      logic exp_l;
      if (!resetn) begin
         chk("rst_uart_tx",   uart_tx,   1);
         chk("rst_tx_busy",   tx_busy,   0);
         chk("rst_fifo_full", fifo_full, 0);
         chk("rst_overflow",  overflow,  0);
         chk("rst_drop_cnt",  drop_cnt,  0);
         mon_act = 1'b0;
      end else begin
         chk("tx_busy",   tx_busy,   ((m_fifo.size() > 0) || (cyc < m_free)) ? 1 : 0);
         chk("fifo_full", fifo_full, (m_fifo.size() == DEPTH) ? 1 : 0);
         chk("overflow",  overflow,  m_ovf);
         chk("drop_cnt",  drop_cnt,  m_drop);
         if (!mon_act) begin
            if (sb_q.size() > 0 && sb_q[0].start == cyc) begin
               mon_act = 1'b1;
               mon_s   = 0;
            end else begin
               chk("line_idle", uart_tx, 1);
            end
         end
         if (mon_act) begin
            if (sb_q.size() == 0) begin
               mon_act = 1'b0;
            end else begin
               bi = mon_s / D;
               if (bi == 0)      exp_l = 1'b0;
               else if (bi <= 8) exp_l = sb_q[0].data[bi-1];
               else              exp_l = 1'b1;
               chk($sformatf("line_%02h_bit%0d", sb_q[0].data, bi), uart_tx, exp_l);
               mon_s++;
               if (mon_s == 10 * D) begin
                  void'(sb_q.pop_front());
                  mon_act = 1'b0;
               end
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [7:0] d);
      pif.print_valid = v;
      pif.print_value = d;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (!(m_fifo.size() == 0 && cyc >= m_free && sb_q.size() == 0 && !mon_act) && n < max) begin
         drive(1'b0, 8'h00);
         n++;
      end
      if (n >= max) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: still busy after %0d cycles, expected idle", max);
      end
      repeat (3) drive(1'b0, 8'h00);
   endtask

   initial begin
      pif.print_valid = 1'b0;
      pif.print_value = 8'h00;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      repeat (2) drive(1'b0, 8'h00);

      // Single byte: latency, bit order, busy fall
      drive(1'b1, 8'h41);
      wait_idle(100);

      // Back-to-back frames
      drive(1'b1, 8'h55);
      drive(1'b1, 8'hAA);
      wait_idle(200);

      // Overflow: 01 popped, 02..05 fill, 06 dropped
      for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
      wait_idle(400);

      // Strobe on the STOP-end pop edge while full: must be accepted
      for (int i = 0; i < 5; i++) drive(1'b1, 8'hB0 + 8'(i));
      for (int n = 0; n < 100 && (cyc + 1) != m_free; n++) drive(1'b0, 8'h00);
      chk("stop_pop_full", fifo_full, 1);
      drive(1'b1, 8'hC3);
      wait_idle(400);

      // Random traffic
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 9) == 0), 8'($urandom));
      wait_idle(400);

      // Reset during DATA bit 3 of F0 with two bytes queued
      drive(1'b1, 8'hF0);
      drive(1'b1, 8'h11);
      drive(1'b1, 8'h22);
      repeat (17) drive(1'b0, 8'h00);
      resetn = 1'b0;
      #1 chk("rst_midframe_line", uart_tx, 1);
      #1;
      repeat (3) drive(1'b1, 8'h77);
      resetn = 1'b1;
      repeat (60) drive(1'b0, 8'h00);

      // Drop counter saturation
      force dut.r_drop_cnt = 16'hFFFE;
      m_drop = 16'hFFFE;
      drive(1'b0, 8'h00);
      release dut.r_drop_cnt;
      for (int i = 0; i < 8; i++) drive(1'b1, 8'h60 + 8'(i));
      drive(1'b0, 8'h00);
      chk("drop_sat", drop_cnt, 16'hFFFF);
      chk("overflow_sticky", overflow, 1);
      wait_idle(500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/print_uart_tx.md
PRINT_UART_TX -- requirements
Module: print_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port print_valid  input  1  one-cycle strobe; print byte present from the data-memory print channel.
REQ-006 SHALL have port print_value  input  8  print byte, sampled when print_valid=1.
REQ-007 SHALL have port uart_tx  output  1  serial line, 8N1, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port overflow  output  1  sticky; a byte was dropped since reset.
REQ-011 SHALL have port drop_cnt  output  16  count of dropped bytes, saturating at 16'hFFFF.

Function
REQ-012 SHALL write print_value into the FIFO on every edge where print_valid=1 and the FIFO is not full, or is full and a pop happens on the same edge.
REQ-013 SHALL discard a byte offered while full with no pop on that edge, set overflow, and increment drop_cnt unless it is already 16'hFFFF.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 In IDLE with FIFO non-empty, the FSM SHALL pop one byte into a shift register and enter START on the same edge.
REQ-016 In IDLE with FIFO empty, the FSM SHALL stay in IDLE.
REQ-017 START SHALL drive uart_tx=0 for exactly CLK_DIV cycles, then enter DATA.
REQ-018 DATA SHALL drive 8 bits LSB first, each for exactly CLK_DIV cycles, using a 3-bit bit index, then enter STOP.
REQ-019 STOP SHALL drive uart_tx=1 for CLK_DIV cycles; on its last cycle the FSM SHALL pop and go directly to START if the FIFO is non-empty, else go to IDLE.
REQ-020 SHALL count bit time with a 16-bit down-counter loaded with CLK_DIV-1 at each bit start; a bit ends when the counter reaches 0.
REQ-021 Latency: with print_valid sampled at edge E0, FIFO empty and FSM IDLE, uart_tx SHALL go low after edge E0+2.
REQ-022 Back-to-back bytes SHALL have no idle gap; frame period is exactly 10*CLK_DIV cycles.
REQ-023 uart_tx SHALL be driven from a register (glitch-free).
REQ-024 tx_busy SHALL be low only when FSM=IDLE and FIFO is empty.
REQ-025 The FIFO SHALL use wrapping pointers of log2(FIFO_DEPTH)+1 bits; full and empty derive from pointer equality and the MSB difference.

Reset
REQ-026 On resetn=0, SHALL asynchronously set uart_tx=1, tx_busy=0, fifo_full=0, overflow=0, drop_cnt=0, FSM=IDLE, FIFO empty, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (line high) and discard FIFO contents; no partial frame resumes after reset.
REQ-028 print_valid during reset SHALL be ignored.

Structure
REQ-029 Package print_uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP), default CLK_DIV and FIFO_DEPTH constants, and DROP_CNT_W=16.
REQ-030 One sub-module, print_fifo (synchronous byte FIFO with push/pop/full/empty), SHALL be instantiated; FSM, bit timer and drop counter live in print_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-031 Single byte 8'h41 at E0 -> uart_tx low E0+2..E0+5; then bits 1,0,0,0,0,0,1,0, 4 cycles each; high stop; tx_busy falls after 40 line cycles.
REQ-032 Bytes 8'h55 and 8'hAA on consecutive cycles -> two frames, 80 contiguous cycles, no idle gap, tx_busy continuously high.
REQ-033 Six strobes on consecutive cycles (8'h01..8'h06) -> 01 popped at once, 02..05 fill FIFO, 06 dropped; overflow=1, drop_cnt=1; line carries 01..05.
REQ-034 With FIFO full, a strobe on the edge the STOP-end pop occurs -> byte accepted, drop_cnt unchanged.
REQ-035 resetn asserted during DATA bit 3 of 8'hF0 with 2 bytes queued -> uart_tx=1 immediately; all outputs at reset values; no frames after release until a new strobe.
REQ-036 Force drop_cnt to 16'hFFFE, drop 3 bytes -> drop_cnt saturates at 16'hFFFF, overflow=1.
